// File: rtl/ofm_wr_sched_if.sv
// Handshake bundle between the OFM write scheduler, the layer sequencer,
// the ping-pong buffer and the AXI OFM writer.
interface ofm_wr_sched_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int CNT_W      = 16
);
  logic                  cfg_start;
  logic [AXI_ADDR_W-1:0] cfg_ofm_base;
  logic [CNT_W-1:0]      cfg_num_bursts;
  logic [1:0]            bank_full;
  logic [1:0]            bank_release;
  logic                  wr_start;
  logic [AXI_ADDR_W-1:0] wr_base_addr;
  logic                  wr_bank_sel;
  logic                  wr_done;
  logic                  busy;
  logic                  layer_done;
  logic                  cfg_err;

  // scheduler side
  modport slave (
    input  cfg_start, cfg_ofm_base, cfg_num_bursts, bank_full, wr_done,
    output bank_release, wr_start, wr_base_addr, wr_bank_sel, busy, layer_done, cfg_err
  );

  // environment side (sequencer, buffer, writer)
  modport master (
    output cfg_start, cfg_ofm_base, cfg_num_bursts, bank_full, wr_done,
    input  bank_release, wr_start, wr_base_addr, wr_bank_sel, busy, layer_done, cfg_err
  );
endinterface

// File: rtl/ofm_wr_sched.sv
// OFM write-back burst scheduler: one writer burst per filled ping-pong bank.
// Optional OFM_WR_SCHED_PERF_EN adds saturating stall/busy cycle counters.

`ifdef OFM_WR_SCHED_PERF_EN
module ofm_wr_sched_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (inc && (cnt != '1))  cnt <= cnt + 1'b1;
  end
endmodule
`endif

module ofm_wr_sched #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 128,
  parameter int BURST_LEN  = 128,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef OFM_WR_SCHED_PERF_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_busy_cycles,
`endif
  ofm_wr_sched_if.slave bus
);

  localparam int BURST_BYTES = BURST_LEN * AXI_DATA_W / 8;
  localparam int OFS_W       = $clog2(BURST_BYTES);
  localparam logic [AXI_ADDR_W-1:0] BURST_INC = AXI_ADDR_W'(BURST_BYTES);

  typedef enum logic [2:0] {
    IDLE, WAIT_BANK, ISSUE, WAIT_DONE, RELEASE, FINISH
  } state_t;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]      left;
    logic                  bank_ptr;
  } ctx_t;

  state_t state;
  ctx_t   ctx;

  logic cfg_aligned;
  logic cfg_accept;

  // A burst-aligned base keeps every burst inside one 4 KB page.
  assign cfg_aligned = (bus.cfg_ofm_base[OFS_W-1:0] == '0);
  assign cfg_accept  = (state == IDLE) && bus.cfg_start && cfg_aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      ctx               <= '0;
      bus.wr_start      <= 1'b0;
      bus.wr_base_addr  <= '0;
      bus.wr_bank_sel   <= 1'b0;
      bus.bank_release  <= '0;
      bus.busy          <= 1'b0;
      bus.layer_done    <= 1'b0;
      bus.cfg_err       <= 1'b0;
    end else begin
      bus.wr_start     <= 1'b0;
      bus.bank_release <= '0;
      bus.layer_done   <= 1'b0;
      bus.cfg_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_start && !cfg_aligned) begin
            bus.cfg_err <= 1'b1;
          end else if (cfg_accept) begin
            bus.busy <= 1'b1;
            if (bus.cfg_num_bursts == '0) begin
              state          <= FINISH;
              bus.layer_done <= 1'b1;
            end else begin
              state <= WAIT_BANK;
              ctx   <= '{cur_addr: bus.cfg_ofm_base,
                         left:     bus.cfg_num_bursts,
                         bank_ptr: 1'b0};
            end
          end
        end
        WAIT_BANK: begin
          // only the bank in turn matters; banks strictly alternate
          if (bus.bank_full[ctx.bank_ptr]) begin
            state            <= ISSUE;
            bus.wr_start     <= 1'b1;
            bus.wr_base_addr <= ctx.cur_addr;
            bus.wr_bank_sel  <= ctx.bank_ptr;
          end
        end
        ISSUE: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.wr_done) begin
            state            <= RELEASE;
            bus.bank_release <= ctx.bank_ptr ? 2'b10 : 2'b01;
          end
        end
        RELEASE: begin
          ctx.cur_addr <= ctx.cur_addr + BURST_INC;
          ctx.left     <= ctx.left - 1'b1;
          ctx.bank_ptr <= ~ctx.bank_ptr;
          if (ctx.left == CNT_W'(1)) begin
            state          <= FINISH;
            bus.layer_done <= 1'b1;
          end else begin
            state <= WAIT_BANK;
          end
        end
        FINISH: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef OFM_WR_SCHED_PERF_EN
  // [0] stall cycles (WAIT_BANK), [1] busy cycles
  logic [1:0]       perf_inc;
  logic [1:0][31:0] perf_cnt;

  assign perf_inc = {bus.busy, (state == WAIT_BANK)};

  for (genvar g = 0; g < 2; g++) begin : g_perf
    ofm_wr_sched_sat_cnt #(.W(32)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cfg_accept),
      .inc   (perf_inc[g]),
      .cnt   (perf_cnt[g])
    );
  end

  assign perf_stall_cycles = perf_cnt[0];
  assign perf_busy_cycles  = perf_cnt[1];
`endif

endmodule
